// File: rtl/mole_score_unit.sv
`default_nettype none
// ============================================================================
// mole_score_unit : whack-a-mole score/miss tracker with 4-state game FSM.
// Optional STREAK_BONUS_EN macro adds hit-streak counting and bonus points.
// Revision: 1.0
// ============================================================================
module mole_score_unit #(
  parameter int N_HOLES    = 8,
  parameter int SCORE_W    = 8,
  parameter int MISS_W     = 8,
  parameter int STREAK_LEN = 4
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               gamestart,
  input  logic               gameend,
  input  logic               mole_valid,
  input  logic [N_HOLES-1:0] mole_pos,
  input  logic [N_HOLES-1:0] switch_in,
  output logic               molehit,
  output logic [N_HOLES-1:0] cmole,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  misses,
  output logic [1:0]         state,
  output logic [7:0]         streak
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam int SCORE_EXT = SCORE_W + 9;
  localparam int MISS_EXT  = MISS_W + 5;

  state_t               state_q, state_d;
  logic [N_HOLES-1:0]   sw_prev;
  logic [N_HOLES-1:0]   tog, hit, miss;
  logic [4:0]           hit_cnt, miss_cnt;
  logic [7:0]           bonus, streak_next;
  logic [SCORE_EXT-1:0] score_sum;
  logic [MISS_EXT-1:0]  miss_sum;
  logic [SCORE_W-1:0]   score_sat;
  logic [MISS_W-1:0]    miss_sat;

  logic [N_HOLES-1:0]   cmole_d;
  logic [SCORE_W-1:0]   score_d;
  logic [MISS_W-1:0]    misses_d;
  logic [7:0]           streak_d;
  logic                 molehit_d;

  function automatic logic [4:0] popcount(input logic [N_HOLES-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < N_HOLES; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

  assign tog      = switch_in ^ sw_prev;
  assign hit      = tog & cmole;
  assign miss     = tog & ~cmole;
  assign hit_cnt  = popcount(hit);
  assign miss_cnt = popcount(miss);

`ifdef STREAK_BONUS_EN
  logic [8:0] streak_sum;
  logic [7:0] streak_acc;

  assign streak_sum  = {1'b0, streak} + {4'd0, hit_cnt};
  assign streak_acc  = streak_sum[8] ? 8'hFF : streak_sum[7:0];
  // One bonus point per multiple of STREAK_LEN passed on the way up.
  assign bonus       = 8'(32'(streak_acc) / STREAK_LEN - 32'(streak) / STREAK_LEN);
  assign streak_next = (|miss) ? 8'd0 : streak_acc;
`else
  logic [31:0] unused_streak_len;

  assign unused_streak_len = 32'(STREAK_LEN);
  assign bonus             = 8'd0;
  assign streak_next       = 8'd0;
`endif

  assign score_sum = SCORE_EXT'(score) + SCORE_EXT'(hit_cnt) + SCORE_EXT'(bonus);
  assign score_sat = (|score_sum[SCORE_EXT-1:SCORE_W]) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  assign miss_sum  = MISS_EXT'(misses) + MISS_EXT'(miss_cnt);
  assign miss_sat  = (|miss_sum[MISS_EXT-1:MISS_W]) ? {MISS_W{1'b1}} : miss_sum[MISS_W-1:0];

  always_comb begin
    state_d   = state_q;
    cmole_d   = cmole;
    score_d   = score;
    misses_d  = misses;
    streak_d  = streak;
    molehit_d = 1'b0;
    if (!gamestart) begin
      state_d  = ST_IDLE;
      cmole_d  = '0;
      score_d  = '0;
      misses_d = '0;
      streak_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = gameend ? ST_OVER : ST_WAIT;
        ST_WAIT, ST_ACTIVE: begin
          if (gameend) begin
            state_d = ST_OVER;
            cmole_d = '0;
          end else if (mole_valid) begin
            // New pattern wins; toggles seen in this cycle are dropped.
            cmole_d = mole_pos;
            state_d = (mole_pos == '0) ? ST_WAIT : ST_ACTIVE;
          end else begin
            cmole_d   = cmole & ~hit;
            score_d   = score_sat;
            misses_d  = miss_sat;
            streak_d  = streak_next;
            molehit_d = |hit;
            state_d   = ((cmole & ~hit) == '0) ? ST_WAIT : ST_ACTIVE;
          end
        end
        ST_OVER: cmole_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    sw_prev <= switch_in;
    if (reset) begin
      state_q <= ST_IDLE;
      cmole   <= '0;
      score   <= '0;
      misses  <= '0;
      streak  <= 8'd0;
      molehit <= 1'b0;
    end else begin
      state_q <= state_d;
      cmole   <= cmole_d;
      score   <= score_d;
      misses  <= misses_d;
      streak  <= streak_d;
      molehit <= molehit_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire
